attention_softmax: RTL and testbench

- Row-wise fixed-point softmax stage, directly upstream of the attention AV multiply.
- Consumes the raw score matrix S (shape L,N,L, from the QK stage) and produces the attention weight matrix A, in the same flattened layout the AV multiply takes as its A input.
- Processes one (l,n) row at a time: max scan, base-2 exponential approximation with sum accumulation, then a sequential restoring divider for normalisation.

---
 rtl/attention_softmax.sv | 231 +++++++++++++++++++++++
 tb/tb_attention_softmax.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attention_softmax.sv
// Row-wise fixed-point softmax stage feeding the attention AV multiply.
// Each (l,n) row is processed in three passes: a signed max scan, a base-2
// exponential approximation with sum accumulation, and a restoring divider
// that normalises every exponential against the row sum.
module attention_softmax #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int FRAC       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DATA_WIDTH*L*N*L-1:0]  scores_in,
    output logic [DATA_WIDTH*L*N*L-1:0]  A_out,
    output logic                         busy,
    output logic                         done,
    output logic                         out_valid
);

    localparam int ROWS   = L * N;
    localparam int ELEMS  = ROWS * L;
    localparam int COL_W  = (L > 1) ? $clog2(L) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ELEM_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int IT_W   = $clog2(FRAC + 1);
    localparam int SUM_W  = DATA_WIDTH + $clog2(L);
    localparam int REM_W  = SUM_W + 1;
    localparam int E_W    = FRAC + 1;
    localparam int Q_W    = FRAC + 1;
    localparam int D_W    = DATA_WIDTH + 1;
    localparam int IP_W   = D_W - FRAC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAX,
        S_EXP,
        S_DIV,
        S_DONE
    } state_t;

    state_t                         state;
    logic [ROW_W-1:0]               row;
    logic [COL_W-1:0]               col;
    logic [IT_W-1:0]                iter;
    logic signed [DATA_WIDTH-1:0]   max_q;
    logic [SUM_W-1:0]               sum_q;
    logic [REM_W-1:0]               rem_q;
    logic [Q_W-1:0]                 quo_q;

    logic [DATA_WIDTH-1:0]          score_mem [ELEMS];
    logic [E_W-1:0]                 e_mem     [L];
    logic [DATA_WIDTH-1:0]          res_mem   [ELEMS];

    logic [ELEM_W-1:0]              elem_idx;
    logic signed [DATA_WIDTH-1:0]   cur_score;
    logic [D_W-1:0]                 diff;
    logic [D_W-1:0]                 neg_diff;
    logic [IP_W-1:0]                ip;
    logic [FRAC-1:0]                fp;
    logic [E_W-1:0]                 mant;
    logic [E_W-1:0]                 e_val;
    logic [REM_W-1:0]               rem_in;
    logic                           rem_ge;
    logic [REM_W-1:0]               rem_nxt;
    logic [Q_W-1:0]                 quo_nxt;

    logic                           last_col;
    logic                           last_row;
    logic                           last_iter;

    assign elem_idx  = ELEM_W'(row) * ELEM_W'(L) + ELEM_W'(col);
    assign cur_score = $signed(score_mem[elem_idx]);
    assign last_col  = (col == COL_W'(L - 1));
    assign last_row  = (row == ROW_W'(ROWS - 1));
    assign last_iter = (iter == IT_W'(FRAC));

    // Exponential approximation: 2^(-p) with a linear mantissa on the fraction
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        diff     = '0;
        neg_diff = '0;
        ip       = '0;
        fp       = '0;
        mant     = '0;
        e_val    = '0;
        // Widened by one bit so most-positive minus most-negative cannot wrap.
        diff     = {cur_score[DATA_WIDTH-1], cur_score} - {max_q[DATA_WIDTH-1], max_q};
        neg_diff = -diff;
        ip       = neg_diff[D_W-1:FRAC];
        fp       = neg_diff[FRAC-1:0];
        mant     = {1'b1, {FRAC{1'b0}}} - {2'b00, fp[FRAC-1:1]};
        if (ip >= IP_W'(FRAC + 1)) begin
            e_val = '0;
        end else begin
            e_val = mant >> ip;
        end
    end

    // One restoring-division step; the first step of an element loads its exponential
    always_comb begin
        rem_in  = '0;
        rem_ge  = 1'b0;
        rem_nxt = '0;
        quo_nxt = '0;
        if (iter == '0) begin
            rem_in = REM_W'(e_mem[col]);
        end else begin
            rem_in = {rem_q[REM_W-2:0], 1'b0};
        end
        rem_ge  = (rem_in >= {1'b0, sum_q});
        rem_nxt = rem_ge ? (rem_in - {1'b0, sum_q}) : rem_in;
        if (iter == '0) begin
            quo_nxt = Q_W'(rem_ge);
        end else begin
            quo_nxt = {quo_q[Q_W-2:0], rem_ge};
        end
    end

    // Control FSM with registered status outputs, max/sum/divider state and A_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            iter      <= '0;
            max_q     <= '0;
            sum_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            A_out     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            done      <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                S_LOAD: begin
                    state <= S_MAX;
                    col   <= '0;
                end
                S_MAX: begin
                    if (col == '0 || cur_score > max_q) begin
                        max_q <= cur_score;
                    end
                    if (last_col) begin
                        col   <= '0;
                        state <= S_EXP;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                S_EXP: begin
                    if (col == '0) begin
                        sum_q <= SUM_W'(e_val);
                    end else begin
                        sum_q <= sum_q + SUM_W'(e_val);
                    end
                    if (last_col) begin
                        col   <= '0;
                        iter  <= '0;
                        state <= S_DIV;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (last_iter) begin
                        iter <= '0;
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                state <= S_DONE;
                            end else begin
                                row   <= row + 1'b1;
                                state <= S_MAX;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    out_valid <= 1'b1;
                    for (int i = 0; i < ELEMS; i++) begin
                        A_out[i*DATA_WIDTH +: DATA_WIDTH] <= res_mem[i];
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Score snapshot, per-row exponentials and normalised results
    // NOTE: these arrays are data-only storage with no reset; LOAD rewrites every score and each result is written before DONE exposes it.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            for (int i = 0; i < ELEMS; i++) begin
                score_mem[i] <= scores_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (state == S_EXP) begin
            e_mem[col] <= e_val;
        end
        if (state == S_DIV && last_iter) begin
            res_mem[elem_idx] <= DATA_WIDTH'(quo_nxt);
        end
    end

endmodule

// File: tb/tb_attention_softmax.sv
// Self-checking bench for attention_softmax: directed rows with known weights,
// randomized rows against an integer softmax model, start handling and reset.
module tb_attention_softmax;

    localparam int DW   = 16;
    localparam int L    = 8;
    localparam int N    = 1;
    localparam int FRAC = 8;
    localparam int ROWS = L * N;
    localparam int TOT  = DW * ROWS * L;
    localparam int LAT  = 2 + ROWS * L * (FRAC + 3);

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [TOT-1:0] scores_in;
    logic [TOT-1:0] A_out;
    logic           busy;
    logic           done;
    logic           out_valid;

    int n_cmp;
    int n_err;

    attention_softmax #(
        .DATA_WIDTH(DW),
        .L         (L),
        .N         (N),
        .FRAC      (FRAC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .scores_in(scores_in),
        .A_out    (A_out),
        .busy     (busy),
        .done     (done),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer softmax reference following the base-2 approximation rules
    function automatic logic [TOT-1:0] ref_softmax(input logic [TOT-1:0] sc);
        logic [TOT-1:0] res;
        logic [DW-1:0]  raw;
        int s [L];
        int e [L];
        int m, sum, p, ip, fp, q;
        res = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int j = 0; j < L; j++) begin
                raw  = sc[(r*L+j)*DW +: DW];
                s[j] = int'($signed(raw));
            end
            m = s[0];
            for (int j = 1; j < L; j++) if (s[j] > m) m = s[j];
            sum = 0;
            for (int j = 0; j < L; j++) begin
                p  = m - s[j];
                ip = p / (1 << FRAC);
                fp = p % (1 << FRAC);
                e[j] = (ip > FRAC) ? 0 : (((1 << FRAC) - fp / 2) >> ip);
                sum += e[j];
            end
            for (int j = 0; j < L; j++) begin
                q = (e[j] * (1 << FRAC)) / sum;
                res[(r*L+j)*DW +: DW] = q[DW-1:0];
            end
        end
        return res;
    endfunction

    function automatic logic [TOT-1:0] rand_scores(input int span);
        logic [TOT-1:0] sc;
        int v;
        for (int i = 0; i < ROWS * L; i++) begin
            if (span == 0) v = int'($urandom);
            else           v = int'($urandom_range(2 * span)) - span;
            sc[i*DW +: DW] = v[DW-1:0];
        end
        return sc;
    endfunction

    task automatic kick();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles from the start-sampling edge until done; bounded.
    task automatic wait_done(input bit pester, output int cyc);
        bit got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            if (pester) start = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            cyc++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        scores_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, out_valid} !== 3'b000 || A_out !== '0) begin
            n_err++;
            $display("FAIL reset_hold: busy/done/valid=%b A_out_nonzero=%0b expected 000 and 0",
                     {busy, done, out_valid}, |A_out);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, out_valid} !== 3'b000 || A_out !== '0) begin
            n_err++;
            $display("FAIL reset_release: busy/done/valid=%b A_out_nonzero=%0b expected 000 and 0",
                     {busy, done, out_valid}, |A_out);
        end
    endtask

    task automatic test_directed();
        logic [TOT-1:0] sc;
        logic [TOT-1:0] expv;
        int dir_exp [5][L];
        int cyc;
        sc = rand_scores(3 << FRAC);
        for (int j = 0; j < L; j++) begin
            sc[(0*L+j)*DW +: DW] = 16'h0000;
            sc[(1*L+j)*DW +: DW] = (j == 0) ? 16'h0000 : 16'hF000;
            sc[(2*L+j)*DW +: DW] = (j == 0) ? 16'h0000 : (j == 1) ? 16'hFF00 : 16'hF000;
            sc[(3*L+j)*DW +: DW] = (j == 0) ? 16'h0100 : (j == 1) ? 16'h0080 : 16'hF000;
            sc[(4*L+j)*DW +: DW] = (j == 0) ? 16'h7FFF : 16'h8000;
            dir_exp[0][j] = 32;
            dir_exp[1][j] = (j == 0) ? 256 : 0;
            dir_exp[2][j] = (j == 0) ? 170 : (j == 1) ? 85 : 0;
            dir_exp[3][j] = (j == 0) ? 146 : (j == 1) ? 109 : 0;
            dir_exp[4][j] = (j == 0) ? 256 : 0;
        end
        scores_in = sc;
        kick();
        wait_done(1'b0, cyc);
        n_cmp++;
        if (cyc != LAT) begin
            n_err++;
            $display("FAIL directed_latency: got %0d cycles expected %0d", cyc, LAT);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL directed_flags: out_valid=%b busy=%b expected 1 0", out_valid, busy);
        end
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < L; j++) begin
                n_cmp++;
                if (A_out[(r*L+j)*DW +: DW] !== dir_exp[r][j][DW-1:0]) begin
                    n_err++;
                    $display("FAIL directed_row%0d_el%0d: got %0d expected %0d",
                             r, j, A_out[(r*L+j)*DW +: DW], dir_exp[r][j]);
                end
            end
        end
        expv = ref_softmax(sc);
        for (int r = 5; r < ROWS; r++) begin
            n_cmp++;
            if (A_out[r*L*DW +: L*DW] !== expv[r*L*DW +: L*DW]) begin
                n_err++;
                $display("FAIL directed_rand_row%0d: got %h expected %h",
                         r, A_out[r*L*DW +: L*DW], expv[r*L*DW +: L*DW]);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL done_one_cycle: done=%b out_valid=%b expected 0 0", done, out_valid);
        end
    endtask

    task automatic test_random();
        logic [TOT-1:0] sc;
        logic [TOT-1:0] expv;
        int cyc;
        int spans [4];
        spans = '{1 << FRAC, 4 << FRAC, 12 << FRAC, 0};
        for (int t = 0; t < 4; t++) begin
            sc        = rand_scores(spans[t]);
            scores_in = sc;
            expv      = ref_softmax(sc);
            kick();
            wait_done(1'b0, cyc);
            n_cmp++;
            if (cyc != LAT) begin
                n_err++;
                $display("FAIL random%0d_latency: got %0d expected %0d", t, cyc, LAT);
            end
            for (int r = 0; r < ROWS; r++) begin
                n_cmp++;
                if (A_out[r*L*DW +: L*DW] !== expv[r*L*DW +: L*DW]) begin
                    n_err++;
                    $display("FAIL random%0d_row%0d: got %h expected %h",
                             t, r, A_out[r*L*DW +: L*DW], expv[r*L*DW +: L*DW]);
                end
            end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_start_while_busy();
        logic [TOT-1:0] sc;
        logic [TOT-1:0] expv;
        int cyc;
        int extra_done;
        int busy_cycles;
        sc        = rand_scores(2 << FRAC);
        scores_in = sc;
        expv      = ref_softmax(sc);
        kick();
        wait_done(1'b1, cyc);
        n_cmp++;
        if (cyc != LAT) begin
            n_err++;
            $display("FAIL busy_start_latency: got %0d expected %0d", cyc, LAT);
        end
        n_cmp++;
        if (A_out !== expv) begin
            n_err++;
            $display("FAIL busy_start_result: row0 got %h expected %h",
                     A_out[0 +: L*DW], expv[0 +: L*DW]);
        end
        extra_done  = 0;
        busy_cycles = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (busy) busy_cycles++;
        end
        n_cmp++;
        if (extra_done != 0 || busy_cycles != 0) begin
            n_err++;
            $display("FAIL busy_start_no_queue: extra_done=%0d busy_cycles=%0d expected 0 0",
                     extra_done, busy_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [TOT-1:0] sc_a;
        logic [TOT-1:0] sc_b;
        logic [TOT-1:0] exp_a;
        logic [TOT-1:0] exp_b;
        int cyc;
        sc_a      = rand_scores(5 << FRAC);
        sc_b      = rand_scores(2 << FRAC);
        exp_a     = ref_softmax(sc_a);
        exp_b     = ref_softmax(sc_b);
        scores_in = sc_a;
        kick();
        wait_done(1'b0, cyc);
        n_cmp++;
        if (A_out !== exp_a) begin
            n_err++;
            $display("FAIL b2b_first_result: row0 got %h expected %h",
                     A_out[0 +: L*DW], exp_a[0 +: L*DW]);
        end
        // Start is raised inside the done cycle itself.
        scores_in = sc_b;
        kick();
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done);
        end
        @(posedge clk);
        #1 scores_in = rand_scores(0);
        wait_done(1'b0, cyc);
        cyc++;
        n_cmp++;
        if (cyc != LAT) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d expected %0d", cyc, LAT);
        end
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++;
            if (A_out[r*L*DW +: L*DW] !== exp_b[r*L*DW +: L*DW]) begin
                n_err++;
                $display("FAIL b2b_second_row%0d: got %h expected %h",
                         r, A_out[r*L*DW +: L*DW], exp_b[r*L*DW +: L*DW]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [TOT-1:0] sc;
        logic [TOT-1:0] expv;
        int cyc;
        int leak;
        sc        = rand_scores(6 << FRAC);
        scores_in = sc;
        kick();
        // Row 3 division occupies cycles 282..353 after the start edge.
        repeat (300) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_precheck: busy=%b expected 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, out_valid} !== 3'b000 || A_out !== '0) begin
            n_err++;
            $display("FAIL midreset_async: busy/done/valid=%b A_out_nonzero=%0b expected 000 and 0",
                     {busy, done, out_valid}, |A_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        leak = 0;
        repeat (LAT + 20) begin
            @(posedge clk);
            #1;
            if (busy || done || out_valid || A_out !== '0) leak++;
        end
        n_cmp++;
        if (leak != 0) begin
            n_err++;
            $display("FAIL midreset_after: %0d cycles with activity expected 0", leak);
        end
        sc        = rand_scores(3 << FRAC);
        scores_in = sc;
        expv      = ref_softmax(sc);
        kick();
        wait_done(1'b0, cyc);
        n_cmp++;
        if (cyc != LAT) begin
            n_err++;
            $display("FAIL midreset_rerun_latency: got %0d expected %0d", cyc, LAT);
        end
        for (int r = 0; r < ROWS; r++) begin
            n_cmp++;
            if (A_out[r*L*DW +: L*DW] !== expv[r*L*DW +: L*DW]) begin
                n_err++;
                $display("FAIL midreset_rerun_row%0d: got %h expected %h",
                         r, A_out[r*L*DW +: L*DW], expv[r*L*DW +: L*DW]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
